// File: rtl/push_button_conditioner.sv
// Two-channel push-button front end: sync, debounce, press/auto-repeat events,
// and a push1-priority arbiter that defers a colliding push2 by one cycle.
module push_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn1,
   input  logic btn2,
   output logic push1,
   output logic push2,
   output logic held1,
   output logic held2
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX);
   localparam bit RPT_EN  = (REPEAT_DELAY > 0);

   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic [1:0] btn_v;
   logic [1:0] held_v;
   logic [1:0] req;
   logic       pending2;

   assign btn_v = {btn2, btn1};

   for (genvar i = 0; i < 2; i++) begin : gen_ch
      logic             s0;
      logic             s1;
      logic             held;
      logic [DB_W-1:0]  cnt;
      logic [RPT_W-1:0] rcnt;
      logic             rep_phase;
      logic             differ;
      logic             accept;
      logic             press;
      logic             fall;
      logic             fire;

      assign differ = (s1 != held);
      assign accept = differ && (cnt == DB_LAST);
      assign press  = accept && s1;
      assign fall   = accept && !s1;

      // A falling edge on the same cycle as a due repeat suppresses the repeat.
      assign fire = RPT_EN && held && !fall &&
                    (rcnt == (rep_phase ? RP_LAST : RD_LAST));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s0   <= 1'b0;
            s1   <= 1'b0;
            held <= 1'b0;
            cnt  <= '0;
         end else begin
            s0 <= btn_v[i];
            s1 <= s0;
            if (accept) held <= s1;
            if (!differ || accept) cnt <= '0;
            else                   cnt <= cnt + DB_W'(1);
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
         end else if (press || !held || fall || !RPT_EN) begin
            rcnt      <= '0;
            rep_phase <= 1'b0;
         end else if (fire) begin
            rcnt      <= '0;
            rep_phase <= 1'b1;
         end else begin
            rcnt <= rcnt + RPT_W'(1);
         end
      end

      assign held_v[i] = held;
      assign req[i]    = press | fire;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         push1    <= 1'b0;
         push2    <= 1'b0;
         pending2 <= 1'b0;
      end else begin
         push1    <= req[0];
         push2    <= !req[0] && (req[1] || pending2);
         pending2 <= req[0] && (req[1] || pending2);
      end
   end

   assign held1 = held_v[0];
   assign held2 = held_v[1];

endmodule

// File: tb/tb_push_button_conditioner.sv
// Bench for push_button_conditioner: directed scenarios plus random button
// traffic, all checked against a window-based behavioural model.
module tb_push_button_conditioner;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic clk;
   logic rst;
   logic btn1;
   logic btn2;
   logic push1;
   logic push2;
   logic held1;
   logic held2;

   int n_checks = 0;
   int n_fail   = 0;

   push_button_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .btn1 (btn1),
      .btn2 (btn2),
      .push1(push1),
      .push2(push2),
      .held1(held1),
      .held2(held2)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Edge numbering restarts at 1 on the first clock after reset release.
   // held toggles once the last DB synchroniser-delayed samples all disagree
   // with it; repeats fall at press+RD, then every RP while held stays high.
   int         ecount;
   logic [1:0] raw_q[$];
   logic [3:0] exp_q[$];
   logic       m_held [2];
   int         press_e [2];
   logic       pend;
   logic [1:0] m_req;
   logic       m_flip;
   logic       m_rep;
   int         m_d;
   logic       m_p1;
   logic       m_p2;

   function automatic logic view(int k, int ch);
      if (k < 3) return 1'b0;
      return raw_q[k-3][ch];
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            ecount = 0;
            raw_q.delete();
            exp_q.delete();
            m_held[0] = 1'b0;
            m_held[1] = 1'b0;
            press_e[0] = 0;
            press_e[1] = 0;
            pend = 1'b0;
         end else begin
            ecount++;
            raw_q.push_back({btn2, btn1});
            for (int ch = 0; ch < 2; ch++) begin
               m_flip = 1'b1;
               for (int j = 0; j < DB; j++)
                  if (view(ecount - j, ch) == m_held[ch]) m_flip = 1'b0;
               m_rep = 1'b0;
               if (RD > 0 && m_held[ch] && !m_flip) begin
                  m_d   = ecount - press_e[ch];
                  m_rep = (m_d == RD) || (m_d > RD && ((m_d - RD) % RP) == 0);
               end
               m_req[ch] = (m_flip && !m_held[ch]) || m_rep;
               if (m_flip && !m_held[ch]) press_e[ch] = ecount;
               if (m_flip) m_held[ch] = !m_held[ch];
            end
            m_p1 = m_req[0];
            m_p2 = !m_req[0] && (m_req[1] || pend);
            pend = m_req[0] && (m_req[1] || pend);
            exp_q.push_back({m_p2, m_p1, m_held[1], m_held[0]});
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [3:0] sb_exp;
   logic [3:0] sb_got;

   initial begin
      forever begin
         @(negedge clk);
         #1;
         sb_got = {push2, push1, held2, held1};
         if (rst) begin
            n_checks++;
            if (sb_got !== 4'b0000) begin
               n_fail++;
               $display("FAIL sb_reset_outputs: got %b expected 0000", sb_got);
            end
         end else if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            n_checks++;
            if (sb_got !== sb_exp) begin
               n_fail++;
               $display("FAIL sb_cycle edge %0d: got {p2,p1,h2,h1}=%b expected %b",
                        ecount, sb_got, sb_exp);
            end
            n_checks++;
            if (push1 && push2) begin
               n_fail++;
               $display("FAIL sb_mutex edge %0d: got push1=1 push2=1 expected not both", ecount);
            end
         end
      end
   end

   // ---------------- driver tasks and event logs ----------------
   int   p1_log[$];
   int   p2_log[$];
   int   h1_rise[$];
   int   h1_fall[$];
   int   h2_rise[$];
   int   overlap;
   logic prev_h1;
   logic prev_h2;

   task automatic clear_logs();
      p1_log.delete();
      p2_log.delete();
      h1_rise.delete();
      h1_fall.delete();
      h2_rise.delete();
      overlap = 0;
      prev_h1 = 1'b0;
      prev_h2 = 1'b0;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      btn1 = 1'b0;
      btn2 = 1'b0;
      repeat (2) @(negedge clk);
      clear_logs();
      rst = 1'b0;
   endtask

   task automatic step(input logic b1, input logic b2);
      btn1 = b1;
      btn2 = b2;
      @(negedge clk);
      if (push1) p1_log.push_back(ecount);
      if (push2) p2_log.push_back(ecount);
      if (push1 && push2) overlap++;
      if (held1 && !prev_h1) h1_rise.push_back(ecount);
      if (!held1 && prev_h1) h1_fall.push_back(ecount);
      if (held2 && !prev_h2) h2_rise.push_back(ecount);
      prev_h1 = held1;
      prev_h2 = held2;
   endtask

   function automatic string edges_str(input int q[$]);
      string s;
      s = "";
      foreach (q[i]) begin
         if (i > 0) s = {s, " "};
         s = {s, $sformatf("%0d", q[i])};
      end
      return s;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst  = 1'b1;
      btn1 = 1'b0;
      btn2 = 1'b0;
      @(posedge clk);
      #3;
      n_checks++;
      if ({push1, push2, held1, held2} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid_cycle: got %b expected 0000", {push1, push2, held1, held2});
      end
      @(negedge clk);
      clear_logs();
      rst = 1'b0;
      step(1'b0, 1'b0);
      n_checks++;
      if ({push1, push2, held1, held2} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_after_release: got %b expected 0000", {push1, push2, held1, held2});
      end
      repeat (50) step(1'b0, 1'b0);
      n_checks++;
      if (p1_log.size() + p2_log.size() + h1_rise.size() + h2_rise.size() != 0) begin
         n_fail++;
         $display("FAIL reset_idle: got %0d events expected 0",
                  p1_log.size() + p2_log.size() + h1_rise.size() + h2_rise.size());
      end
   endtask

   task automatic test_glitch();
      do_reset();
      repeat (3) step(1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0);
      n_checks++;
      if (edges_str(p1_log) != "" || edges_str(h1_rise) != "") begin
         n_fail++;
         $display("FAIL glitch_reject: got push1 at '%s' held1 rise at '%s' expected none",
                  edges_str(p1_log), edges_str(h1_rise));
      end
      do_reset();
      repeat (4) step(1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0);
      n_checks++;
      if (edges_str(p1_log) != "6") begin
         n_fail++;
         $display("FAIL glitch_min_pulse_push: got '%s' expected '6'", edges_str(p1_log));
      end
      n_checks++;
      if (edges_str(h1_rise) != "6" || edges_str(h1_fall) != "10") begin
         n_fail++;
         $display("FAIL glitch_min_pulse_held: got rise '%s' fall '%s' expected rise '6' fall '10'",
                  edges_str(h1_rise), edges_str(h1_fall));
      end
   endtask

   task automatic test_hold_repeat();
      do_reset();
      repeat (30) step(1'b1, 1'b0);
      repeat (15) step(1'b0, 1'b0);
      n_checks++;
      if (edges_str(p1_log) != "6 16 21 26 31") begin
         n_fail++;
         $display("FAIL repeat_edges: got '%s' expected '6 16 21 26 31'", edges_str(p1_log));
      end
      n_checks++;
      if (edges_str(h1_rise) != "6" || edges_str(h1_fall) != "36") begin
         n_fail++;
         $display("FAIL repeat_held: got rise '%s' fall '%s' expected rise '6' fall '36'",
                  edges_str(h1_rise), edges_str(h1_fall));
      end
      n_checks++;
      if (p2_log.size() != 0) begin
         n_fail++;
         $display("FAIL repeat_no_push2: got %0d push2 expected 0", p2_log.size());
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      repeat (6) step(1'b1, 1'b1);
      repeat (12) step(1'b0, 1'b0);
      n_checks++;
      if (edges_str(p1_log) != "6" || edges_str(p2_log) != "7") begin
         n_fail++;
         $display("FAIL simul_push: got push1 '%s' push2 '%s' expected push1 '6' push2 '7'",
                  edges_str(p1_log), edges_str(p2_log));
      end
      n_checks++;
      if (edges_str(h1_rise) != "6" || edges_str(h2_rise) != "6") begin
         n_fail++;
         $display("FAIL simul_held: got held1 '%s' held2 '%s' expected '6' '6'",
                  edges_str(h1_rise), edges_str(h2_rise));
      end
      n_checks++;
      if (overlap != 0) begin
         n_fail++;
         $display("FAIL simul_overlap: got %0d overlapping cycles expected 0", overlap);
      end
   endtask

   task automatic test_bouncy();
      logic [5:0] pat;
      do_reset();
      pat = 6'b101101;
      for (int i = 5; i >= 0; i--) step(1'b0, pat[i]);
      repeat (7) step(1'b0, 1'b1);
      repeat (12) step(1'b0, 1'b0);
      n_checks++;
      if (edges_str(p2_log) != "11" || p1_log.size() != 0) begin
         n_fail++;
         $display("FAIL bouncy_push2: got push2 '%s' push1 count %0d expected push2 '11' push1 count 0",
                  edges_str(p2_log), p1_log.size());
      end
      n_checks++;
      if (edges_str(h2_rise) != "11") begin
         n_fail++;
         $display("FAIL bouncy_held2: got '%s' expected '11'", edges_str(h2_rise));
      end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      repeat (20) step(1'b1, 1'b0);
      n_checks++;
      if (edges_str(p1_log) != "6 16") begin
         n_fail++;
         $display("FAIL midhold_before: got '%s' expected '6 16'", edges_str(p1_log));
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({push1, push2, held1, held2} !== 4'b0000) begin
         n_fail++;
         $display("FAIL midhold_async_clear: got %b expected 0000", {push1, push2, held1, held2});
      end
      @(negedge clk);
      @(negedge clk);
      clear_logs();
      rst = 1'b0;
      repeat (8) step(1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0);
      n_checks++;
      if (edges_str(p1_log) != "6") begin
         n_fail++;
         $display("FAIL midhold_after: got '%s' expected '6'", edges_str(p1_log));
      end
   endtask

   task automatic test_random();
      logic l1;
      logic l2;
      int   r1;
      int   r2;
      do_reset();
      l1 = 1'b0;
      l2 = 1'b0;
      r1 = 1;
      r2 = 1;
      for (int c = 0; c < 600; c++) begin
         r1 = r1 - 1;
         if (r1 == 0) begin
            l1 = ~l1;
            r1 = $urandom_range(1, 24);
         end
         r2 = r2 - 1;
         if (r2 == 0) begin
            l2 = ~l2;
            r2 = $urandom_range(1, 24);
         end
         step(l1, l2);
      end
      repeat (20) step(1'b0, 1'b0);
      n_checks++;
      if (overlap != 0) begin
         n_fail++;
         $display("FAIL random_overlap: got %0d overlapping cycles expected 0", overlap);
      end
   endtask

   initial begin
      rst  = 1'b1;
      btn1 = 1'b0;
      btn2 = 1'b0;
      clear_logs();
      test_reset();
      test_glitch();
      test_hold_repeat();
      test_simultaneous();
      test_bouncy();
      test_reset_mid_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
